// File: rtl/boot_loader_arb_pkg.sv
// Shared definitions for the UART boot loader: FSM state encodings, frame constants.
// Optional checksum checking is enabled with the BOOT_CHECKSUM_EN macro.
package boot_loader_arb_pkg;

    localparam int unsigned STATE_W    = 3;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned LEN_BYTES  = 2;
    localparam int unsigned ADR_BYTES  = 2;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] ST_LEN0 = 3'd1;
    localparam logic [STATE_W-1:0] ST_LEN1 = 3'd2;
    localparam logic [STATE_W-1:0] ST_ADR0 = 3'd3;
    localparam logic [STATE_W-1:0] ST_ADR1 = 3'd4;
    localparam logic [STATE_W-1:0] ST_DATA = 3'd5;
    localparam logic [STATE_W-1:0] ST_CHK  = 3'd6;
    localparam logic [STATE_W-1:0] ST_ERR  = 3'd7;

    // Frame states are the contiguous range LEN0..CHK.
    function automatic logic in_frame(input logic [STATE_W-1:0] st);
        return (st >= ST_LEN0) && (st <= ST_CHK);
    endfunction

    // Bytes of header after the sync byte (length + start address).
    function automatic int unsigned hdr_bytes();
        return LEN_BYTES + ADR_BYTES;
    endfunction

endpackage

// File: rtl/boot_loader_arb_word_asm.sv
// Little-endian byte-to-word assembler with a one-cycle word-ready pulse.
// With BOOT_CHECKSUM_EN defined it also keeps a running XOR of the bytes.
module boot_word_asm
    import boot_loader_arb_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_vld_o,
`ifdef BOOT_CHECKSUM_EN
    output logic [7:0]  xor_o,
`endif
    output logic [1:0]  byte_cnt_o
);

    logic [31:0] word_q, word_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        vld_q, vld_d;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]  xor_q, xor_d;
`endif

    // New bytes enter at the top so that byte 0 ends in [7:0] after four shifts.
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        vld_d  = 1'b0;
`ifdef BOOT_CHECKSUM_EN
        xor_d  = xor_q;
`endif
        if (clr_i) begin
            cnt_d = '0;
`ifdef BOOT_CHECKSUM_EN
            xor_d = '0;
`endif
        end else if (byte_vld_i) begin
            word_d = {byte_i, word_q[31:8]};
            cnt_d  = cnt_q + 2'd1;
            vld_d  = (cnt_q == 2'(WORD_BYTES - 1));
`ifdef BOOT_CHECKSUM_EN
            xor_d  = xor_q ^ byte_i;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q <= '0;
            cnt_q  <= '0;
            vld_q  <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            xor_q  <= '0;
`endif
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
`ifdef BOOT_CHECKSUM_EN
            xor_q  <= xor_d;
`endif
        end
    end

    assign word_o     = word_q;
    assign word_vld_o = vld_q;
    assign byte_cnt_o = cnt_q;
`ifdef BOOT_CHECKSUM_EN
    assign xor_o      = xor_q;
`endif

endmodule

// File: rtl/boot_loader_arb.sv
// UART boot loader: parses load frames, writes BRAM port B and holds the CPU in reset.
// Define BOOT_CHECKSUM_EN to make the trailing CHK byte an XOR checksum of the data bytes.
module boot_loader_arb
    import boot_loader_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 13,
    parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [31:0]       i_cpu_data,
    input  logic [3:0]        i_cpu_wr,
    output logic [ADDR_W-1:0] o_bram_addr,
    output logic [31:0]       o_bram_data,
    output logic [3:0]        o_bram_wr,
    output logic              o_cpu_rst,
    output logic              o_busy,
    output logic              o_err
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [15:0]        words_left_q, words_left_d;
    logic [7:0]         start_lo_q, start_lo_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               busy_q, busy_d;
    logic               cpu_rst_q, cpu_rst_d;
    logic               err_q, err_d;

    logic               sync_c;
    logic               asm_clr_c;
    logic               asm_vld_c;
    logic               word_done_c;
    logic               chk_ok_c;
    logic [31:0]        asm_word;
    logic               asm_word_vld;
    logic [1:0]         asm_byte_cnt;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]         asm_xor;
`endif

    assign sync_c      = i_rx_valid && (i_rx_data == SYNC_BYTE);
    assign asm_clr_c   = sync_c && ((state_q == ST_IDLE) || (state_q == ST_ERR));
    assign asm_vld_c   = i_rx_valid && (state_q == ST_DATA);
    assign word_done_c = asm_vld_c && (asm_byte_cnt == 2'(WORD_BYTES - 1));

`ifdef BOOT_CHECKSUM_EN
    assign chk_ok_c = (i_rx_data == asm_xor);
`else
    assign chk_ok_c = 1'b1;
`endif

    boot_word_asm u_word_asm (
        .clk_i      (i_clk),
        .rst_i      (i_rst),
        .clr_i      (asm_clr_c),
        .byte_vld_i (asm_vld_c),
        .byte_i     (i_rx_data),
        .word_o     (asm_word),
        .word_vld_o (asm_word_vld),
`ifdef BOOT_CHECKSUM_EN
        .xor_o      (asm_xor),
`endif
        .byte_cnt_o (asm_byte_cnt)
    );

    // Next-state and datapath updates.
    always_comb begin
        state_d      = state_q;
        tmo_d        = tmo_q;
        words_left_d = words_left_q;
        start_lo_d   = start_lo_q;
        addr_d       = addr_q;

        // Advance the write pointer once the current word has been written.
        if (asm_word_vld) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (sync_c) begin
                    state_d      = ST_LEN0;
                    words_left_d = '0;
                end
            end
            ST_LEN0: begin
                if (i_rx_valid) begin
                    words_left_d[7:0] = i_rx_data;
                    state_d           = ST_LEN1;
                end
            end
            ST_LEN1: begin
                if (i_rx_valid) begin
                    words_left_d[15:8] = i_rx_data;
                    state_d            = ST_ADR0;
                end
            end
            ST_ADR0: begin
                if (i_rx_valid) begin
                    start_lo_d = i_rx_data;
                    state_d    = ST_ADR1;
                end
            end
            ST_ADR1: begin
                if (i_rx_valid) begin
                    addr_d  = ADDR_W'({i_rx_data, start_lo_q});
                    state_d = (words_left_q == 16'd0) ? ST_CHK : ST_DATA;
                end
            end
            ST_DATA: begin
                if (word_done_c) begin
                    words_left_d = words_left_q - 16'd1;
                    if (words_left_q == 16'd1) begin
                        state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (i_rx_valid) begin
                    state_d = chk_ok_c ? ST_IDLE : ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Inter-byte timeout: only counts silent cycles while a frame is open.
        if (in_frame(state_q)) begin
            if (i_rx_valid) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                tmo_d   = '0;
                state_d = ST_ERR;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end else begin
            tmo_d = '0;
        end

        busy_d    = in_frame(state_d);
        cpu_rst_d = (state_d != ST_IDLE);
        err_d     = (state_d == ST_ERR);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            tmo_q        <= '0;
            words_left_q <= '0;
            start_lo_q   <= '0;
            addr_q       <= '0;
            busy_q       <= 1'b0;
            cpu_rst_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            words_left_q <= words_left_d;
            start_lo_q   <= start_lo_d;
            addr_q       <= addr_d;
            busy_q       <= busy_d;
            cpu_rst_q    <= cpu_rst_d;
            err_q        <= err_d;
        end
    end

    // Port B belongs to the loader while a frame is open, to the CPU otherwise.
    assign o_bram_addr = busy_q ? addr_q : i_cpu_addr;
    assign o_bram_data = busy_q ? asm_word : i_cpu_data;
    assign o_bram_wr   = busy_q ? (asm_word_vld ? 4'hF : 4'h0) : i_cpu_wr;

    assign o_cpu_rst = cpu_rst_q;
    assign o_busy    = busy_q;
    assign o_err     = err_q;

endmodule

// File: doc/boot_loader_arb.md
Name: boot_loader_arb

Overview:
- UART-driven program loader that owns BRAM data port B while loading; otherwise passes CPU data-port writes straight through.
- Sits between CPU data port, UART receive byte stream and BRAM port B in top level.
- Holds CPU in reset during a load frame, then releases it so the CPU restarts from the new image.

Parameters:
- ADDR_W, 13, BRAM word-address width; top forms port address as {addr, 1'b0}.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYC, 1000000, idle-byte cycles inside a frame before abort.

Ports:
- i_clk  in  1  system clock (BRAM clocked on inverted i_clk at top level).
- i_rst  in  1  synchronous active-high reset.
- i_rx_valid  in  1  one-cycle pulse: i_rx_data holds a received byte.
- i_rx_data  in  8  received UART byte.
- i_cpu_addr  in  ADDR_W  CPU data word address.
- i_cpu_data  in  32  CPU write data.
- i_cpu_wr  in  4  CPU byte write enables, already qualified with BRAM select.
- o_bram_addr  out  ADDR_W  port B word address.
- o_bram_data  out  32  port B write data.
- o_bram_wr  out  4  port B byte write enables.
- o_cpu_rst  out  1  CPU reset request, ORed into CPU reset at top.
- o_busy  out  1  high while a frame is in progress.
- o_err  out  1  sticky: last frame aborted; cleared by next SYNC_BYTE.

Behaviour:
- One clock (i_clk); synchronous active-high reset i_rst. Reset: state IDLE, o_cpu_rst=0, o_busy=0, o_err=0, o_bram_wr=0, all counters 0.
- Frame, little-endian: SYNC_BYTE, LEN[7:0], LEN[15:8], START[7:0], START[15:8], 4*LEN data bytes, CHK byte.
- FSM states: IDLE, LEN0, LEN1, ADR0, ADR1, DATA, CHK, ERR.
- IDLE: i_rx_valid with SYNC_BYTE -> LEN0. Other bytes are ignored.
- LEN0 -> LEN1 -> ADR0 -> ADR1: each transition on one i_rx_valid.
- ADR1 exit: LEN==0 -> CHK, else -> DATA.
- START is truncated to ADDR_W bits.
- DATA:
  - Bytes shift into a 32-bit assembler, byte 0 in [7:0].
  - The cycle after the 4th byte, o_bram_wr=4'hF for exactly 1 cycle, with o_bram_addr=START+word_idx (mod 2^ADDR_W, wraps silently) and o_bram_data=assembled word.
  - After the LEN-th word -> CHK.
- CHK: see optional feature. Pass -> IDLE with o_err=0; fail -> ERR with o_err=1.
- Timeout: in LEN0..CHK, the counter resets on every i_rx_valid. Reaching TIMEOUT_CYC -> ERR.
- ERR: holds o_cpu_rst=1, o_err=1. SYNC_BYTE -> LEN0 and clears o_err.
- o_cpu_rst:
  - Registered. Set the cycle after SYNC_BYTE is accepted; held through the frame and in ERR.
  - Deasserted the cycle after successful CHK, but not before the final BRAM write cycle has completed.
- o_busy: 1 in LEN0..CHK.
- Port mux:
  - o_busy=0: o_bram_* = CPU inputs, combinational.
  - o_busy=1: loader drives o_bram_*. CPU writes are dropped (CPU is in reset anyway).
- A byte arriving in the same cycle as the BRAM write pulse is accepted normally; no bytes are lost.
- i_rst mid-frame: immediate return to IDLE. A partial image stays in BRAM; o_cpu_rst drops.

Optional Feature:
- BOOT_CHECKSUM_EN defined:
  - Running XOR of all data bytes (LEN, START and SYNC excluded), seeded 8'h00.
  - CHK byte must equal it; mismatch -> ERR.
- Undefined: CHK byte is consumed but ignored; always pass. The XOR logic is not synthesised.

Decomposition:
- Shared package/header: FSM state encodings, SYNC_BYTE default, frame field byte counts.
- One natural sub-module: boot_word_asm (byte shift-in, byte counter, word-ready pulse, optional XOR).
- FSM, timeout and port mux stay in the top of the block.

Test Plan:
- Frame A5 02 00 10 00, data 11 22 33 44 55 66 77 88, CHK 88 -> writes 0x44332211 @0x0010 and 0x88776655 @0x0011; o_cpu_rst pulses high then low; o_err=0.
- Same frame with CHK 00:
  - with BOOT_CHECKSUM_EN: both words written; ERR entered, o_cpu_rst stays 1, o_err=1.
  - without BOOT_CHECKSUM_EN: pass.
- Frame A5 00 00 05 00, CHK 00 -> no o_bram_wr pulse; back to IDLE; o_cpu_rst released.
- START=0x1FFF, LEN=2 -> writes at 0x1FFF then 0x0000 (wrap).
- Stop sending after 3 data bytes, wait TIMEOUT_CYC (bench TIMEOUT_CYC=50) -> ERR, o_err=1. Next A5 clears o_err and reaches LEN0.
- o_busy=0, CPU write addr 0x0020 data 0xDEADBEEF wr 4'b0011 -> passed to BRAM the same cycle. Same write while o_busy=1 -> o_bram_wr=0.
